// File: rtl/text_buffer_ctrl_if.sv
// Command channel between a requester and text_buffer_ctrl.
// The requester holds op/data stable while cmd_valid is high until cmd_ready accepts it.
interface text_buffer_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;

  modport master (output cmd_valid, output cmd_op, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, input cmd_data, output cmd_ready);
endinterface

// File: rtl/text_buffer_ctrl.sv
// 4x16 character buffer with a write cursor, a command port and a 64-cycle clear sequencer.
// The display read port is purely combinational and never waits on command traffic.
module text_buffer_ctrl #(
  parameter logic [7:0] CLEAR_CHAR = 8'd32
) (
  input  logic                     clk,
  input  logic                     rst,
  text_buffer_ctrl_if.slave        cmd,
  input  logic [5:0]               charAddress,
  output logic [7:0]               charOutput,
  output logic [5:0]               cursor,
  output logic                     busy
);

  typedef enum logic {IDLE, CLEAR} state_t;
  typedef enum logic [1:0] {OP_PUT, OP_SETCUR, OP_CLEAR, OP_BKSP} op_t;

  localparam logic [7:0] NEWLINE = 8'h0A;

  state_t     state, nextState;
  logic [5:0] clrIdx, nextClrIdx;
  logic [5:0] nextCursor;
  logic [1:0] nextRow;
  logic       wrEn;
  logic [5:0] wrAddr;
  logic [7:0] wrData;
  op_t        op;

  logic [7:0] mem [64];

  assign charOutput    = mem[charAddress];
  assign cmd.cmd_ready = (state == IDLE);
  assign busy          = (state == CLEAR);
  assign op            = op_t'(cmd.cmd_op);
  assign nextRow       = cursor[5:4] + 2'd1;

  // NOTE: every signal gets a default before the case so no path leaves one unassigned and infers a latch.
  always_comb begin
    nextState  = state;
    nextClrIdx = clrIdx;
    nextCursor = cursor;
    wrEn       = 1'b0;
    wrAddr     = cursor;
    wrData     = cmd.cmd_data;

    case (state)
      IDLE: begin
        if (cmd.cmd_valid) begin
          case (op)
            OP_PUT: begin
              if (cmd.cmd_data == NEWLINE) begin
                nextCursor = {nextRow, 4'b0000};
              end else begin
                wrEn       = 1'b1;
                nextCursor = cursor + 6'd1;
              end
            end
            OP_SETCUR: nextCursor = cmd.cmd_data[5:0];
            OP_CLEAR: begin
              nextState  = CLEAR;
              nextClrIdx = 6'd0;
            end
            OP_BKSP: begin
              wrEn       = 1'b1;
              wrAddr     = cursor - 6'd1;
              wrData     = CLEAR_CHAR;
              nextCursor = cursor - 6'd1;
            end
            default: ;
          endcase
        end
      end
      CLEAR: begin
        wrEn       = 1'b1;
        wrAddr     = clrIdx;
        wrData     = CLEAR_CHAR;
        nextClrIdx = clrIdx + 6'd1;
        // Cursor is homed only together with the last clear write.
        if (clrIdx == 6'd63) begin
          nextState  = IDLE;
          nextCursor = 6'd0;
        end
      end
      default: nextState = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= CLEAR;
      clrIdx <= 6'd0;
      cursor <= 6'd0;
    end else begin
      state  <= nextState;
      clrIdx <= nextClrIdx;
      cursor <= nextCursor;
    end
  end

  // NOTE: the storage array has no reset branch; the post-reset clear sequence initialises it.
  always_ff @(posedge clk) begin
    if (wrEn && !rst) begin
      mem[wrAddr] <= wrData;
    end
  end

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Self-checking bench for text_buffer_ctrl: a behavioural buffer model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_text_buffer_ctrl;

  localparam logic [7:0] CLEAR_CHAR = 8'd32;
  localparam logic [1:0] PUT = 2'b00, SETCUR = 2'b01, CLR = 2'b10, BKSP = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] charAddress;
  logic [7:0] charOutput;
  logic [5:0] cursor;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int cycle    = 0;

  text_buffer_ctrl_if cmdBus ();

  text_buffer_ctrl #(.CLEAR_CHAR(CLEAR_CHAR)) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd         (cmdBus.slave),
    .charAddress (charAddress),
    .charOutput  (charOutput),
    .cursor      (cursor),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Behavioural model: a 64-entry array, a cursor, and a count of clear writes still owed.
  logic [7:0] modelMem   [64];
  bit         modelKnown [64];
  int         clearLeft   = 64;
  int         modelCursor = 0;

  always @(posedge clk) begin
    if (rst) begin
      clearLeft   = 64;
      modelCursor = 0;
    end else if (clearLeft > 0) begin
      modelMem[64 - clearLeft]   = CLEAR_CHAR;
      modelKnown[64 - clearLeft] = 1'b1;
      clearLeft--;
      if (clearLeft == 0) modelCursor = 0;
    end else if (cmdBus.cmd_valid) begin
      case (cmdBus.cmd_op)
        PUT: begin
          if (cmdBus.cmd_data == 8'h0A) begin
            modelCursor = ((modelCursor / 16 + 1) % 4) * 16;
          end else begin
            modelMem[modelCursor]   = cmdBus.cmd_data;
            modelKnown[modelCursor] = 1'b1;
            modelCursor = (modelCursor + 1) % 64;
          end
        end
        SETCUR: modelCursor = cmdBus.cmd_data % 64;
        CLR:    clearLeft = 64;
        BKSP: begin
          modelCursor = (modelCursor + 63) % 64;
          modelMem[modelCursor] = CLEAR_CHAR;
        end
        default: ;
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    check("model_ready", {31'd0, cmdBus.cmd_ready}, {31'd0, clearLeft == 0});
    check("model_busy", {31'd0, busy}, {31'd0, clearLeft > 0});
    check("model_cursor", {26'd0, cursor}, modelCursor);
    if (modelKnown[charAddress]) begin
      check("model_char", {24'd0, charOutput}, {24'd0, modelMem[charAddress]});
    end
  end

  // Called on a falling edge; returns on the falling edge after the command was accepted.
  task automatic sendCmd(input logic [1:0] op, input logic [7:0] data, output int waited);
    waited = 0;
    cmdBus.cmd_valid = 1'b1;
    cmdBus.cmd_op    = op;
    cmdBus.cmd_data  = data;
    while (!cmdBus.cmd_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!cmdBus.cmd_ready) check("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic idleBus();
    cmdBus.cmd_valid = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [5:0] addr, input logic [7:0] expected);
    @(negedge clk);
    charAddress = addr;
    #1;
    check(name, {24'd0, charOutput}, {24'd0, expected});
  endtask

  // Called right after rst is dropped on a falling edge; counts cycles with busy high.
  task automatic countClear(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  int w;
  int n;
  int startCycle;

  initial begin
    rst              = 1'b1;
    cmdBus.cmd_valid = 1'b0;
    cmdBus.cmd_op    = PUT;
    cmdBus.cmd_data  = 8'd0;
    charAddress      = 6'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    countClear(n);

    // One-cycle reset pulse followed by the full clear
    rst = 1'b1;
    @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd1);
    check("reset_ready", {31'd0, cmdBus.cmd_ready}, 32'd0);
    rst = 1'b0;
    countClear(n);
    check("clear_len", n, 64);
    check("clear_ready", {31'd0, cmdBus.cmd_ready}, 32'd1);
    check("clear_cursor", {26'd0, cursor}, 32'd0);
    for (int i = 0; i < 64; i++) readCheck("clear_read", 6'(i), 8'd32);

    // Back-to-back PUT A, B, C
    @(negedge clk);
    startCycle = cycle;
    sendCmd(PUT, 8'h41, w);
    sendCmd(PUT, 8'h42, w);
    sendCmd(PUT, 8'h43, w);
    idleBus();
    check("abc_cycles", cycle - startCycle, 3);
    check("abc_cursor", {26'd0, cursor}, 32'd3);
    readCheck("abc_0", 6'd0, 8'h41);
    readCheck("abc_1", 6'd1, 8'h42);
    readCheck("abc_2", 6'd2, 8'h43);

    // Cursor wrap at 63 and backspace back across it; upper SETCUR bits ignored
    @(negedge clk);
    sendCmd(SETCUR, 8'hFF, w);
    check("setcur_63", {26'd0, cursor}, 32'd63);
    sendCmd(PUT, 8'h5A, w);
    idleBus();
    check("wrap_cursor", {26'd0, cursor}, 32'd0);
    readCheck("wrap_char", 6'd63, 8'h5A);
    @(negedge clk);
    sendCmd(BKSP, 8'h00, w);
    idleBus();
    check("bksp_cursor", {26'd0, cursor}, 32'd63);
    readCheck("bksp_char", 6'd63, 8'd32);

    // Out-of-range code stored unchanged, then backspace wrapping from 0
    @(negedge clk);
    sendCmd(SETCUR, 8'h10, w);
    sendCmd(PUT, 8'hFF, w);
    idleBus();
    check("raw_cursor", {26'd0, cursor}, 32'h11);
    readCheck("raw_char", 6'h10, 8'hFF);
    @(negedge clk);
    sendCmd(SETCUR, 8'h00, w);
    sendCmd(BKSP, 8'h00, w);
    idleBus();
    check("bksp0_cursor", {26'd0, cursor}, 32'd63);

    // Newline handling, including the row 3 wrap
    @(negedge clk);
    sendCmd(SETCUR, 8'h15, w);
    sendCmd(PUT, 8'h0A, w);
    idleBus();
    check("nl_cursor", {26'd0, cursor}, 32'h20);
    readCheck("nl_nowrite", 6'h15, 8'd32);
    @(negedge clk);
    sendCmd(SETCUR, 8'h35, w);
    sendCmd(PUT, 8'h0A, w);
    idleBus();
    check("nl_wrap", {26'd0, cursor}, 32'h00);
    readCheck("nl_nowrite2", 6'h35, 8'd32);

    // CLEAR with a PUT held pending behind it; cursor frozen at 0x25 meanwhile
    @(negedge clk);
    sendCmd(SETCUR, 8'h25, w);
    sendCmd(CLR, 8'h00, w);
    check("hold_busy", {31'd0, busy}, 32'd1);
    check("hold_cursor", {26'd0, cursor}, 32'h25);
    sendCmd(PUT, 8'h58, w);
    idleBus();
    check("hold_wait", w, 64);
    check("hold_cursor_after", {26'd0, cursor}, 32'd1);
    readCheck("hold_char", 6'd0, 8'h58);
    readCheck("hold_cleared", 6'd1, 8'd32);

    // Reset in the middle of a CLEAR restarts it from index 0
    @(negedge clk);
    sendCmd(PUT, 8'h51, w);
    sendCmd(SETCUR, 8'h09, w);
    sendCmd(CLR, 8'h00, w);
    idleBus();
    repeat (30) @(negedge clk);
    check("mid_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    countClear(n);
    check("restart_len", n, 64);
    check("restart_cursor", {26'd0, cursor}, 32'd0);
    for (int i = 0; i < 64; i++) readCheck("restart_read", 6'(i), 8'd32);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
